kid_hit_detector: RTL and testbench
===================================

KID_HIT_DETECTOR -- requirements
Module: kid_hit_detector

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800: visible columns per frame.
REQ-002 SHALL have parameter V_ACTIVE, default 600: visible rows per frame.
REQ-003 SHALL have parameter MIN_OVERLAP, default 4: overlapping pixels per frame that kill the kid.
REQ-004 SHALL have parameter GRACE_FRAMES, default 60: frames of invulnerability after respawn.
REQ-005 SHALL have port clk, input, 1: single system/pixel clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port col, input, 10: current scan column.
REQ-008 SHALL have port row, input, 10: current scan row.
REQ-009 SHALL have port is_kid, input, 1: kid sprite opaque at (col,row).
REQ-010 SHALL have port is_hazard, input, 1: OR of all hazard is_* flags (apples, spikes) at (col,row).
REQ-011 SHALL have port respawn, input, 1: one-cycle respawn request from game control.
REQ-012 SHALL have port dead, output, 1: kid is dead (level).
REQ-013 SHALL have port death_pulse, output, 1: one-cycle strobe on death.
REQ-014 SHALL have port overlap_cnt, output, 12: overlap count of the last completed frame.

Function
REQ-015 SHALL sample is_kid&is_hazard once per clk, counting it only when col<H_ACTIVE and row<V_ACTIVE.
REQ-016 SHALL accumulate into a 12-bit running counter saturating at 4095 (no wrap).
REQ-017 SHALL define frame end as the cycle with col==H_ACTIVE-1 and row==V_ACTIVE-1; that pixel's sample SHALL be included.
REQ-018 At frame end, SHALL load overlap_cnt with the final total (including that pixel) and clear the running counter to 0 on the next cycle.
REQ-019 SHALL implement FSM states ALIVE, DEAD, GRACE (GRACE only per REQ-027).
REQ-020 ALIVE: at frame end, if final total >= MIN_OVERLAP, SHALL go to DEAD and assert death_pulse for exactly one cycle, the cycle after frame end.
REQ-021 DEAD: dead=1; overlaps SHALL still be counted but SHALL NOT produce further death_pulse.
REQ-022 DEAD + respawn: SHALL leave DEAD next cycle (to GRACE or ALIVE per REQ-027/028), clear running counter; dead deasserts same cycle as state change.
REQ-023 respawn in ALIVE or GRACE SHALL clear the running counter and otherwise be ignored.
REQ-024 respawn coinciding with a killing frame end in ALIVE: death SHALL win (DEAD, death_pulse), respawn dropped.
REQ-025 Total below MIN_OVERLAP (including 0) SHALL leave ALIVE unchanged; MIN_OVERLAP=0 is illegal.

Reset
REQ-026 rst SHALL force ALIVE, dead=0, death_pulse=0, overlap_cnt=0, running counter=0, grace counter=0, taking priority over all inputs, including mid-frame and mid-grace.

Configuration
REQ-027 With RESPAWN_GRACE_EN defined: DEAD+respawn SHALL enter GRACE; GRACE counts frame ends in a counter and returns to ALIVE on the GRACE_FRAMES-th frame end; no death possible in GRACE; dead=0 in GRACE.
REQ-028 Without RESPAWN_GRACE_EN: GRACE state and counter SHALL not exist; DEAD+respawn SHALL go directly to ALIVE.

Verification
REQ-029 Reset, then frame with 4 overlap pixels (MIN_OVERLAP=4) -> death_pulse one cycle after frame end, dead=1, overlap_cnt=4.
REQ-030 Frame with 3 overlap pixels -> no death_pulse, dead=0, overlap_cnt=3.
REQ-031 Single overlap at (799,599) plus 3 earlier -> death counted; overlap at (800,10) -> ignored.
REQ-032 Dead, respawn, with RESPAWN_GRACE_EN and GRACE_FRAMES=2: 10-overlap frames -> no death for 2 frame ends, then death on 3rd frame end; without macro -> death at 1st frame end.
REQ-033 Full-screen overlap (480000 pixels) -> overlap_cnt=4095, death_pulse once.
REQ-034 rst asserted mid-frame after 3 overlaps, then 1 overlap -> no death, overlap_cnt=1 at frame end.

Source files
------------

// File: rtl/kid_hit_detector.sv
// Kid/hazard collision detector: counts opaque kid-over-hazard pixels per frame and kills the kid.
// Latency: overlap_cnt, dead and death_pulse update on the edge that ends the frame (pulse lasts one cycle).
// Backpressure: none; one pixel sample per clk. Optional macro RESPAWN_GRACE_EN adds post-respawn grace.
module kid_hit_detector #(
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 600,
  parameter int MIN_OVERLAP  = 4,
  parameter int GRACE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  input  logic        is_kid,
  input  logic        is_hazard,
  input  logic        respawn,
  output logic        dead,
  output logic        death_pulse,
  output logic [11:0] overlap_cnt
);

  localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
  localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [11:0] KILL_MIN = 12'(MIN_OVERLAP);

`ifdef RESPAWN_GRACE_EN
  typedef enum logic [1:0] {ALIVE = 2'd0, DEAD = 2'd1, GRACE = 2'd2} state_t;
  localparam int            GW         = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES);
  localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_FRAMES - 1);
  logic [GW-1:0] grace_q, grace_d;
`else
  typedef enum logic [1:0] {ALIVE = 2'd0, DEAD = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] ovl_q, ovl_d;
  logic        pulse_q, pulse_d;

  logic        hit;
  logic        frame_end;
  logic [11:0] total;
  logic        kill;

  // Per-pixel sample, frame-end detection and the saturating total including this pixel
  always_comb begin
    hit       = is_kid && is_hazard && ({1'b0, col} < H_LIM) && ({1'b0, row} < V_LIM);
    frame_end = (col == H_LAST) && (row == V_LAST);
    total     = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + {11'd0, hit};
    kill      = (state_q == ALIVE) && frame_end && (total >= KILL_MIN);
  end

  // Running counter, last-frame count and the registered death strobe
  always_comb begin
    cnt_d   = total;
    ovl_d   = ovl_q;
    pulse_d = kill;
    if (frame_end) begin
      ovl_d = total;
      cnt_d = 12'd0;
    end
    if (respawn) begin
      cnt_d = 12'd0;
    end
  end

  // Next-state logic; a killing frame end in ALIVE beats a simultaneous respawn
  always_comb begin
    state_d = state_q;
`ifdef RESPAWN_GRACE_EN
    grace_d = grace_q;
`endif
    case (state_q)
      ALIVE: begin
        if (kill) state_d = DEAD;
      end
      DEAD: begin
        if (respawn) begin
`ifdef RESPAWN_GRACE_EN
          state_d = GRACE;
          grace_d = '0;
`else
          state_d = ALIVE;
`endif
        end
      end
`ifdef RESPAWN_GRACE_EN
      GRACE: begin
        if (frame_end) begin
          if (grace_q == GRACE_LAST) state_d = ALIVE;
          else                       grace_d = grace_q + 1'b1;
        end
      end
`endif
      default: state_d = ALIVE;
    endcase
  end

  // Output decode: dead follows the state directly, so it drops on the same edge the state leaves DEAD
  always_comb begin
    dead        = (state_q == DEAD);
    death_pulse = pulse_q;
    overlap_cnt = ovl_q;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALIVE;
      cnt_q   <= 12'd0;
      ovl_q   <= 12'd0;
      pulse_q <= 1'b0;
`ifdef RESPAWN_GRACE_EN
      grace_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovl_q   <= ovl_d;
      pulse_q <= pulse_d;
`ifdef RESPAWN_GRACE_EN
      grace_q <= grace_d;
`endif
    end
  end

endmodule

// File: tb/tb_kid_hit_detector.sv
// Directed bench for kid_hit_detector: vector table plus hand-written multi-cycle sequences.
// Inputs driven on the falling edge, outputs sampled 1ns after the rising edge.
// Expectations follow RESPAWN_GRACE_EN when the bench is built with that macro.
module tb_kid_hit_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  col, row;
  logic        is_kid, is_hazard, respawn;
  logic        dead, death_pulse;
  logic [11:0] overlap_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kid_hit_detector #(
    .H_ACTIVE(800), .V_ACTIVE(600), .MIN_OVERLAP(4), .GRACE_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .col(col), .row(row),
    .is_kid(is_kid), .is_hazard(is_hazard), .respawn(respawn),
    .dead(dead), .death_pulse(death_pulse), .overlap_cnt(overlap_cnt)
  );

  typedef struct {
    logic [9:0]  c;
    logic [9:0]  r;
    logic        k;
    logic        h;
    logic        rsp;
    logic        e_dead;
    logic        e_pulse;
    logic [11:0] e_cnt;
  } vec_t;

  vec_t vecs [15];

  task automatic step(input logic [9:0] c, input logic [9:0] r, input logic k,
                      input logic h, input logic rsp, input logic rs);
    @(negedge clk);
    col = c; row = r; is_kid = k; is_hazard = h; respawn = rsp; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic e_dead, input logic e_pulse,
                       input logic [11:0] e_cnt);
    checks++;
    if (dead !== e_dead || death_pulse !== e_pulse || overlap_cnt !== e_cnt) begin
      failures++;
      $display("FAIL %s: got dead=%b pulse=%b cnt=%0d, want dead=%b pulse=%b cnt=%0d",
               name, dead, death_pulse, overlap_cnt, e_dead, e_pulse, e_cnt);
    end
  endtask

  // n hit cycles inside the screen, then a frame end without a hit
  task automatic frame(input int n);
    for (int i = 0; i < n; i++) step(10'd5, 10'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step(10'd799, 10'd599, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic exp_dead;
  logic exp_pulse;

  initial begin
    //          col      row      k     h     rsp   dead  pulse cnt
    vecs[0]  = '{10'd5,   10'd5,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[1]  = '{10'd6,   10'd5,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[2]  = '{10'd10,  10'd600, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[3]  = '{10'd799, 10'd599, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd3};
    vecs[4]  = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd3};
    vecs[5]  = '{10'd10,  10'd10,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd3};
    vecs[6]  = '{10'd11,  10'd10,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd3};
    vecs[7]  = '{10'd12,  10'd10,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd3};
    vecs[8]  = '{10'd800, 10'd10,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd3};
    vecs[9]  = '{10'd14,  10'd10,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd3};
    vecs[10] = '{10'd799, 10'd599, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'd4};
    vecs[11] = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd4};
    vecs[12] = '{10'd5,   10'd5,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd4};
    vecs[13] = '{10'd799, 10'd599, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'd2};
    vecs[14] = '{10'd0,   10'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd2};

    col = '0; row = '0; is_kid = 1'b0; is_hazard = 1'b0; respawn = 1'b0; rst = 1'b1;
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset", 1'b0, 1'b0, 12'd0);

    // Table: 3-overlap frame, 4-overlap killing frame with edge pixels, counting while dead, respawn
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].c, vecs[i].r, vecs[i].k, vecs[i].h, vecs[i].rsp, 1'b0);
      check($sformatf("vec%0d", i), vecs[i].e_dead, vecs[i].e_pulse, vecs[i].e_cnt);
    end

    // Heavy-overlap frames right after respawn: grace holds off death for two frame ends
    for (int f = 1; f <= 3; f++) begin
      frame(10);
`ifdef RESPAWN_GRACE_EN
      exp_dead  = (f == 3);
      exp_pulse = (f == 3);
`else
      exp_dead  = 1'b1;
      exp_pulse = (f == 1);
`endif
      check($sformatf("grace_frame%0d", f), exp_dead, exp_pulse, 12'd10);
    end

    // Reset while dead returns everything to idle
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_dead", 1'b0, 1'b0, 12'd0);

    // Respawn in ALIVE only clears the running count
    for (int i = 0; i < 3; i++) step(10'd20, 10'd20, 1'b1, 1'b1, 1'b0, 1'b0);
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("respawn_alive", 1'b0, 1'b0, 12'd0);
    frame(2);
    check("respawn_alive_frame", 1'b0, 1'b0, 12'd2);

    // Killing frame end coinciding with respawn: death wins
    for (int i = 0; i < 3; i++) step(10'd20, 10'd20, 1'b1, 1'b1, 1'b0, 1'b0);
    step(10'd799, 10'd599, 1'b1, 1'b1, 1'b1, 1'b0);
    check("kill_vs_respawn", 1'b1, 1'b1, 12'd4);
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("kill_vs_respawn_after", 1'b1, 1'b0, 12'd4);

    // Saturation: far more than 4095 overlaps in a frame
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(4200);
    check("saturate", 1'b1, 1'b1, 12'd4095);
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("saturate_once", 1'b1, 1'b0, 12'd4095);

    // Reset mid-frame discards earlier overlaps
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(10'd30, 10'd30, 1'b1, 1'b1, 1'b0, 1'b0);
    step(10'd31, 10'd30, 1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_midframe", 1'b0, 1'b0, 12'd0);
    frame(1);
    check("after_midframe_reset", 1'b0, 1'b0, 12'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
